trg_ack_monitor: RTL and testbench
==================================

# trg_ack_monitor

Per-SCROD trigger/acknowledge monitor on the 42 MHz trigger clock domain, directly downstream of the trigger generator. Each masked trigger round launched on TRG is tracked until every enabled SCROD returns an ACK edge or a timeout expires. The block reports round completion, per-channel timeouts, saturating per-channel miss counters and a round counter. Its outputs feed the Wishbone register slave for host readback.

## Interface
Parameters:
- N_CH, 12: number of SCROD channels.
- TIMEOUT, 255: cycles to wait for ACKs; 8-bit range, must be 1..255.
- CNT_W, 16: width of per-channel miss counters.

Ports:
- CLK_42MHZ  in  1  trigger-domain clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- TRG  in  N_CH  trigger lines as driven to SCRODs; synchronous to CLK_42MHZ.
- ACK  in  N_CH  SCROD acknowledges; asynchronous.
- TRG_MASK  in  N_CH  enabled channels; sampled only at round start.
- CLEAR  in  1  synchronous clear of TRG_COUNT, all miss counters, TIMEOUT_MASK and ACK_LATENCY.
- CH_SEL  in  4  channel select for MISS_COUNT; values >= N_CH read 0.
- BUSY  out  1  high in WAIT and CLOSE.
- EVT_DONE  out  1  one-cycle pulse on round close.
- EVT_ALL_ACK  out  1  qualified by EVT_DONE; 1 = no timeouts in the round.
- TIMEOUT_MASK  out  N_CH  channels unacked at the last close; holds until the next close.
- TRG_COUNT  out  32  accepted rounds; wraps modulo 2^32.
- MISS_COUNT  out  CNT_W  registered miss count of channel CH_SEL.
- ACK_LATENCY  out  8  timer value at the last ACK edge of the last round; present only with the macro.

Reset value of every output is 0.

## Operation
- Each ACK bit passes through a 2-flop synchronizer followed by a registered rising-edge detector (ack_rise).
- TRG rising edge: trg_rise = TRG & ~TRG_q.
- FSM IDLE:
  - Go to WAIT when (trg_rise & TRG_MASK) != 0.
  - On that transition: pending <= TRG_MASK, timer <= 0, TRG_COUNT += 1.
  - A zero mask never starts a round.
  - ack_rise is ignored in IDLE.
- FSM WAIT:
  - pending <= pending & ~ack_rise.
  - timer += 1.
  - If the next value of pending is 0, go to CLOSE.
  - Else, if timer == TIMEOUT, go to CLOSE.
  - New trg_rise events are ignored; they are not counted.
- FSM CLOSE (exactly one cycle):
  - EVT_DONE = 1.
  - TIMEOUT_MASK <= pending.
  - EVT_ALL_ACK = (pending == 0).
  - For every set bit of pending, that channel's miss counter += 1, saturating at 2^CNT_W-1.
  - Return to IDLE.
- An ACK edge on a channel that is not pending, or a repeated edge, has no effect.
- TRG_MASK changes during WAIT or CLOSE have no effect on the current round.
- CLEAR coinciding with CLOSE: CLEAR wins for counters and TIMEOUT_MASK; EVT_DONE and EVT_ALL_ACK still pulse. CLEAR does not change FSM state.
- CLEAR coinciding with round start: TRG_COUNT becomes 0, not 1.
- RESET_N low mid-round: FSM returns to IDLE immediately; pending, timer, counters and synchronizers are cleared; no EVT_DONE.

## Timing
- TRG edge to BUSY high: 1 cycle.
- Async ACK edge to its pending bit clearing: 3-4 cycles (2 synchronizer cycles, 1 edge-detect cycle, plus sampling uncertainty).
- Last ACK edge detected at timer value t: EVT_DONE 1 cycle later; ACK_LATENCY = t.
- No ACK: EVT_DONE at cycle TIMEOUT+2 after the TRG edge cycle.
- Minimum spacing between rounds: 1 IDLE cycle after CLOSE.
- MISS_COUNT is registered: 1-cycle latency from CH_SEL.

## Configuration
- TRG_MON_LATENCY_EN defined:
  - ACK_LATENCY register and port are present.
  - It updates on every ack_rise that clears a pending bit.
  - Cleared by CLEAR and by reset.
- TRG_MON_LATENCY_EN undefined:
  - The ACK_LATENCY port is absent.
  - No latency logic is synthesized.
  - All other behaviour is identical.

## Structure
- Shared package trg_mon_pkg holds:
  - FSM state encoding (IDLE, WAIT, CLOSE).
  - Default constants for N_CH, TIMEOUT and CNT_W.
- One sub-module, trg_ack_sync:
  - Per-bit 2-flop synchronizer plus rising-edge detect.
  - Instantiated once, N_CH wide.
- Miss counters are an N_CH x CNT_W register array in the top-level block.

## Test plan
- Mask 0x00F, TRG bits 0-3 pulse, ACKs on channels 0-3 after 10 cycles -> one EVT_DONE; EVT_ALL_ACK = 1; TIMEOUT_MASK = 0x000; TRG_COUNT = 1.
- Mask 0xFFF, ACK withheld on channels 5 and 11 -> EVT_DONE at cycle 257; TIMEOUT_MASK = 0x820; MISS_COUNT for CH_SEL = 5 and CH_SEL = 11 reads 1.
- CNT_W = 4, 20 rounds with no ACK on channel 0 -> MISS_COUNT for channel 0 saturates at 15.
- Second TRG edge mid-WAIT and mask changed to 0x000 mid-WAIT -> TRG_COUNT increments once; the round completes on the original pending set.
- CLEAR asserted in the CLOSE cycle of a timed-out round -> TIMEOUT_MASK = 0; counters = 0; EVT_DONE still pulses.
- RESET_N pulsed low during WAIT -> all outputs 0 asynchronously; a later ACK causes no EVT_DONE; the next round behaves normally. With TRG_MON_LATENCY_EN defined, ACK_LATENCY = 0 after reset.

Source files
------------

// File: rtl/trg_mon_pkg.sv
// rtl/trg_mon_pkg.sv - shared FSM encoding and default constants for the trigger/ack monitor
package trg_mon_pkg;

    localparam int DEF_N_CH    = 12;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CLOSE = 2'd2
    } trg_mon_state_t;

endpackage

// File: rtl/trg_ack_sync.sv
// rtl/trg_ack_sync.sv - per-bit 2-flop synchronizer with registered rising-edge detect
//
// Ports:
//   clk        in   sampling clock
//   rst_n      in   asynchronous active-low reset
//   ack_async  in   WIDTH asynchronous acknowledge lines
//   ack_rise   out  WIDTH one-cycle pulses, one per synchronized rising edge
module trg_ack_sync #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ack_async,
    output logic [WIDTH-1:0] ack_rise
);

    logic [WIDTH-1:0] ack_meta;
    logic [WIDTH-1:0] ack_sync;
    logic [WIDTH-1:0] ack_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta   <= '0;
            ack_sync   <= '0;
            ack_sync_q <= '0;
            ack_rise   <= '0;
        end else begin
            ack_meta   <= ack_async;
            ack_sync   <= ack_meta;
            ack_sync_q <= ack_sync;
            ack_rise   <= ack_sync & ~ack_sync_q;
        end
    end

endmodule

// File: rtl/trg_ack_monitor.sv
// rtl/trg_ack_monitor.sv - per-SCROD trigger/acknowledge round monitor with timeouts and miss counters
//
// Optional feature macro: TRG_MON_LATENCY_EN (adds the ACK_LATENCY register and port).
//
// Ports:
//   CLK_42MHZ     in   trigger-domain clock
//   RESET_N       in   asynchronous active-low reset
//   TRG           in   N_CH trigger lines, synchronous
//   ACK           in   N_CH asynchronous acknowledges
//   TRG_MASK      in   N_CH enabled channels, sampled at round start
//   CLEAR         in   synchronous clear of counters, TIMEOUT_MASK, ACK_LATENCY
//   CH_SEL        in   channel select for MISS_COUNT
//   BUSY          out  round in progress (WAIT or CLOSE)
//   EVT_DONE      out  one-cycle round-close pulse
//   EVT_ALL_ACK   out  round closed without timeouts (valid with EVT_DONE)
//   TIMEOUT_MASK  out  channels unacked at the last close
//   TRG_COUNT     out  accepted rounds, wrapping
//   MISS_COUNT    out  registered miss count of channel CH_SEL
//   ACK_LATENCY   out  timer value at the last pending-clearing ACK edge (macro only)
module trg_ack_monitor
    import trg_mon_pkg::*;
#(
    parameter int N_CH    = DEF_N_CH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              CLK_42MHZ,
    input  logic              RESET_N,
    input  logic [N_CH-1:0]   TRG,
    input  logic [N_CH-1:0]   ACK,
    input  logic [N_CH-1:0]   TRG_MASK,
    input  logic              CLEAR,
    input  logic [3:0]        CH_SEL,
    output logic              BUSY,
    output logic              EVT_DONE,
    output logic              EVT_ALL_ACK,
    output logic [N_CH-1:0]   TIMEOUT_MASK,
    output logic [31:0]       TRG_COUNT,
    output logic [CNT_W-1:0]  MISS_COUNT
`ifdef TRG_MON_LATENCY_EN
    ,
    output logic [7:0]        ACK_LATENCY
`endif
);

    localparam logic [7:0]       TIMEOUT_L = 8'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    trg_mon_state_t state, state_nxt;

    logic [N_CH-1:0]  trg_q;
    logic [N_CH-1:0]  trg_rise;
    logic [N_CH-1:0]  ack_rise;
    logic [N_CH-1:0]  pending;
    logic [N_CH-1:0]  pending_cleared;
    logic [7:0]       timer;
    logic             round_start;
    logic [CNT_W-1:0] miss_cnt [N_CH];
    logic [CNT_W-1:0] sel_cnt;

    trg_ack_sync #(
        .WIDTH (N_CH)
    ) u_ack_sync (
        .clk       (CLK_42MHZ),
        .rst_n     (RESET_N),
        .ack_async (ACK),
        .ack_rise  (ack_rise)
    );

    assign trg_rise        = TRG & ~trg_q;
    assign round_start     = (state == ST_IDLE) && ((trg_rise & TRG_MASK) != '0);
    assign pending_cleared = pending & ~ack_rise;

    // State register
    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (round_start) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Close as soon as the last pending bit is about to clear,
                // otherwise when the timer has reached the limit.
                if (pending_cleared == '0 || timer == TIMEOUT_L) begin
                    state_nxt = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Moore outputs; pending holds its final value through CLOSE
    always_comb begin
        BUSY        = (state == ST_WAIT) || (state == ST_CLOSE);
        EVT_DONE    = (state == ST_CLOSE);
        EVT_ALL_ACK = (state == ST_CLOSE) && (pending == '0);
    end

    // Round datapath: trigger history, pending set and timer
    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            trg_q   <= '0;
            pending <= '0;
            timer   <= '0;
        end else begin
            trg_q <= TRG;
            if (round_start) begin
                pending <= TRG_MASK;
                timer   <= '0;
            end else if (state == ST_WAIT) begin
                pending <= pending_cleared;
                timer   <= timer + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            TRG_COUNT <= '0;
        end else if (CLEAR) begin
            TRG_COUNT <= '0;
        end else if (round_start) begin
            TRG_COUNT <= TRG_COUNT + 32'd1;
        end
    end

    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            TIMEOUT_MASK <= '0;
        end else if (CLEAR) begin
            TIMEOUT_MASK <= '0;
        end else if (state == ST_CLOSE) begin
            TIMEOUT_MASK <= pending;
        end
    end

    // Saturating per-channel miss counters, bumped for each channel still pending at close
    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < N_CH; i++) begin
                miss_cnt[i] <= '0;
            end
        end else if (CLEAR) begin
            for (int i = 0; i < N_CH; i++) begin
                miss_cnt[i] <= '0;
            end
        end else if (state == ST_CLOSE) begin
            for (int i = 0; i < N_CH; i++) begin
                if (pending[i] && miss_cnt[i] != CNT_MAX) begin
                    miss_cnt[i] <= miss_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Selects outside the channel range read as zero
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (CH_SEL == 4'(i)) begin
                sel_cnt = miss_cnt[i];
            end
        end
    end

    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            MISS_COUNT <= '0;
        end else if (CLEAR) begin
            MISS_COUNT <= '0;
        end else begin
            MISS_COUNT <= sel_cnt;
        end
    end

`ifdef TRG_MON_LATENCY_EN
    // Captures the timer on every edge that actually retires a pending bit,
    // so after close it holds the latency of the last acknowledging channel.
    always_ff @(posedge CLK_42MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            ACK_LATENCY <= '0;
        end else if (CLEAR) begin
            ACK_LATENCY <= '0;
        end else if (state == ST_WAIT && (pending & ack_rise) != '0) begin
            ACK_LATENCY <= timer;
        end
    end
`else
    // Latency tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_trg_ack_monitor.sv
// tb/tb_trg_ack_monitor.sv - self-checking bench for trg_ack_monitor
module tb_trg_ack_monitor;

    localparam int N_CH  = 12;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_CH-1:0]   trg;
    logic [N_CH-1:0]   ack;
    logic [N_CH-1:0]   trg_mask;
    logic              clear;
    logic [3:0]        ch_sel;
    logic              busy;
    logic              evt_done;
    logic              evt_all_ack;
    logic [N_CH-1:0]   timeout_mask;
    logic [31:0]       trg_count;
    logic [CNT_W-1:0]  miss_count;
`ifdef TRG_MON_LATENCY_EN
    logic [7:0]        ack_latency;
`endif

    always #5 clk = ~clk;

    trg_ack_monitor #(
        .N_CH    (N_CH),
        .TIMEOUT (255),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK_42MHZ    (clk),
        .RESET_N      (rst_n),
        .TRG          (trg),
        .ACK          (ack),
        .TRG_MASK     (trg_mask),
        .CLEAR        (clear),
        .CH_SEL       (ch_sel),
        .BUSY         (busy),
        .EVT_DONE     (evt_done),
        .EVT_ALL_ACK  (evt_all_ack),
        .TIMEOUT_MASK (timeout_mask),
        .TRG_COUNT    (trg_count),
        .MISS_COUNT   (miss_count)
`ifdef TRG_MON_LATENCY_EN
        ,
        .ACK_LATENCY  (ack_latency)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Knobs for the hand-written corner-case rounds
    int              retrg_at = 0;
    bit              use_mask_after = 1'b0;
    logic [N_CH-1:0] mask_after = '0;
    bit              clear_on_done = 1'b0;
    bit              clear_at_start = 1'b0;

    typedef struct {
        logic [N_CH-1:0] mask;
        logic [N_CH-1:0] trg;
        logic [N_CH-1:0] acks;
        int              ack_at;
        int              limit;
        int              done_lo;
        int              done_hi;
        bit              all_ack;
        logic [N_CH-1:0] tmask;
        logic [31:0]     cnt;
        bit              busy1;
    } vec_t;

    typedef struct {
        logic [3:0]       sel;
        logic [CNT_W-1:0] exp;
    } miss_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Cycle 0 is the cycle TRG is driven; done_cyc is the cycle EVT_DONE is seen (-1 if never).
    task automatic run_round(
        input  logic [N_CH-1:0] mask,
        input  logic [N_CH-1:0] trg_bits,
        input  logic [N_CH-1:0] acks,
        input  int              ack_at,
        input  int              limit,
        output int              done_cyc,
        output bit              all_ack,
        output logic [N_CH-1:0] tmask,
        output logic [31:0]     cnt,
        output bit              busy1
    );
        trg_mask = mask;
        trg      = trg_bits;
        ack      = '0;
        if (clear_at_start) clear = 1'b1;
        done_cyc = -1;
        all_ack  = 1'b0;
        busy1    = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            tick();
            if (c == 1) begin
                trg   = '0;
                clear = 1'b0;
                busy1 = busy;
            end
            if (evt_done && done_cyc < 0) begin
                done_cyc = c;
                all_ack  = evt_all_ack;
                if (clear_on_done) clear = 1'b1;
            end
            if (retrg_at > 0 && c == retrg_at) begin
                trg = trg_bits;
                if (use_mask_after) trg_mask = mask_after;
            end
            if (retrg_at > 0 && c == retrg_at + 1) trg = '0;
            if (c == ack_at) ack = acks;
            if (done_cyc >= 0) break;
        end
        tick();
        clear = 1'b0;
        trg   = '0;
        tmask = timeout_mask;
        cnt   = trg_count;
        ack   = '0;
        repeat (5) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            vecs [7];
        miss_vec_t       mvecs [8];
        int              done_cyc;
        bit              all_ack;
        bit              busy1;
        bit              seen;
        int              good_rounds;
        logic [N_CH-1:0] tmask;
        logic [31:0]     cnt;

        //          mask     trg      acks     at  lim  lo   hi  all   tmask    cnt busy1
        vecs[0] = '{12'h00F, 12'h00F, 12'h00F, 10, 300, 13,  14, 1'b1, 12'h000, 1, 1'b1};
        vecs[1] = '{12'hFFF, 12'hFFF, 12'h7DF, 20, 300, 257, 257, 1'b0, 12'h820, 2, 1'b1};
        vecs[2] = '{12'h0F0, 12'h010, 12'h0F0, 5,  300, 8,   9,  1'b1, 12'h000, 3, 1'b1};
        vecs[3] = '{12'h003, 12'h004, 12'h003, 2,  20,  -1,  -1, 1'b0, 12'h000, 3, 1'b0};
        vecs[4] = '{12'h000, 12'hFFF, 12'hFFF, 2,  20,  -1,  -1, 1'b0, 12'h000, 3, 1'b0};
        vecs[5] = '{12'h300, 12'h300, 12'h100, 3,  300, 257, 257, 1'b0, 12'h200, 4, 1'b1};
        vecs[6] = '{12'h001, 12'h001, 12'h002, 3,  300, 257, 257, 1'b0, 12'h001, 5, 1'b1};

        mvecs[0] = '{4'd0,  4'd1};
        mvecs[1] = '{4'd1,  4'd0};
        mvecs[2] = '{4'd5,  4'd1};
        mvecs[3] = '{4'd9,  4'd1};
        mvecs[4] = '{4'd10, 4'd0};
        mvecs[5] = '{4'd11, 4'd1};
        mvecs[6] = '{4'd12, 4'd0};
        mvecs[7] = '{4'd15, 4'd0};

        rst_n = 1'b0; trg = '0; ack = '0; trg_mask = '0; clear = 1'b0; ch_sel = '0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(evt_done), 32'd0);
        check("reset_tmask", 32'(timeout_mask), 32'd0);
        check("reset_count", trg_count, 32'd0);
        check("reset_miss", 32'(miss_count), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 7; i++) begin
            run_round(vecs[i].mask, vecs[i].trg, vecs[i].acks, vecs[i].ack_at, vecs[i].limit,
                      done_cyc, all_ack, tmask, cnt, busy1);
            check($sformatf("v%0d_busy1", i), 32'(busy1), 32'(vecs[i].busy1));
            check_range($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].done_lo, vecs[i].done_hi);
            if (vecs[i].done_lo >= 0) begin
                check($sformatf("v%0d_all_ack", i), 32'(all_ack), 32'(vecs[i].all_ack));
            end
            check($sformatf("v%0d_tmask", i), 32'(tmask), 32'(vecs[i].tmask));
            check($sformatf("v%0d_count", i), cnt, vecs[i].cnt);
`ifdef TRG_MON_LATENCY_EN
            if (i == 0) check_range("v0_latency", int'(ack_latency), 12, 13);
`endif
        end

        for (int i = 0; i < 8; i++) begin
            ch_sel = mvecs[i].sel;
            tick();
            check($sformatf("miss_sel%0d", mvecs[i].sel), 32'(miss_count), 32'(mvecs[i].exp));
        end

        // Retrigger and mask drop mid-WAIT: one count, original pending set kept
        retrg_at = 5; use_mask_after = 1'b1; mask_after = '0;
        run_round(12'h003, 12'h003, 12'h001, 10, 300, done_cyc, all_ack, tmask, cnt, busy1);
        retrg_at = 0; use_mask_after = 1'b0;
        check_range("retrg_done_cycle", done_cyc, 257, 257);
        check("retrg_tmask", 32'(tmask), 32'h002);
        check("retrg_count", cnt, 32'd6);

        // Reset in the middle of a round
        ch_sel = 4'd0;
        trg_mask = 12'h00F; trg = 12'h00F;
        tick();
        trg = '0;
        repeat (4) tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_miss0", 32'(miss_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_count", trg_count, 32'd0);
        check("async_reset_tmask", 32'(timeout_mask), 32'd0);
        check("async_reset_miss", 32'(miss_count), 32'd0);
`ifdef TRG_MON_LATENCY_EN
        check("async_reset_latency", 32'(ack_latency), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        ack = 12'h00F;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (evt_done || busy) seen = 1'b1;
        end
        check("post_reset_no_event", 32'(seen), 32'd0);
        ack = '0;
        repeat (5) tick();

        run_round(12'h001, 12'h001, 12'h001, 4, 300, done_cyc, all_ack, tmask, cnt, busy1);
        check_range("after_reset_done_cycle", done_cyc, 7, 8);
        check("after_reset_all_ack", 32'(all_ack), 32'd1);
        check("after_reset_count", cnt, 32'd1);

        // CLEAR on the round-start cycle wins over the increment
        clear_at_start = 1'b1;
        run_round(12'h001, 12'h001, 12'h001, 4, 300, done_cyc, all_ack, tmask, cnt, busy1);
        clear_at_start = 1'b0;
        check_range("clr_start_done_cycle", done_cyc, 7, 8);
        check("clr_start_count", cnt, 32'd0);

        // Miss counter saturation on channel 0
        ch_sel = 4'd0;
        good_rounds = 0;
        for (int r = 0; r < 20; r++) begin
            run_round(12'h001, 12'h001, 12'h000, 0, 300, done_cyc, all_ack, tmask, cnt, busy1);
            if (done_cyc == 257 && !all_ack && tmask == 12'h001) good_rounds++;
            if (r == 13) check("miss0_after14", 32'(miss_count), 32'd14);
        end
        check("sat_rounds_timed_out", 32'(good_rounds), 32'd20);
        check("miss0_saturated", 32'(miss_count), 32'd15);
        check("sat_count", trg_count, 32'd20);

        // CLEAR in the CLOSE cycle of a timed-out round
        clear_on_done = 1'b1;
        run_round(12'h004, 12'h004, 12'h000, 0, 300, done_cyc, all_ack, tmask, cnt, busy1);
        clear_on_done = 1'b0;
        check_range("clr_close_done_cycle", done_cyc, 257, 257);
        check("clr_close_all_ack", 32'(all_ack), 32'd0);
        check("clr_close_tmask", 32'(tmask), 32'd0);
        check("clr_close_count", cnt, 32'd0);
        ch_sel = 4'd0;
        tick();
        check("clr_close_miss0", 32'(miss_count), 32'd0);
        ch_sel = 4'd2;
        tick();
        check("clr_close_miss2", 32'(miss_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
